// File: rtl/fetch_seq_pkg.sv
// Shared encodings and limits for the fetch/decode stage sequencer.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [1:0] TF_SEQ = 2'b00;

    localparam int LOAD_CYCLES_MAX  = 255;
    localparam int FLUSH_CYCLES_MAX = 15;

    // One phase counter serves both LOAD and FLUSH, so size it for the larger limit.
    localparam int SEQ_CNT_W = $clog2(LOAD_CYCLES_MAX + 1);

    function automatic logic is_busy(input state_t s);
        return (s == ST_LOAD) || (s == ST_RUN) || (s == ST_FLUSH);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the EX load and the ID sources.
module load_use_detect (
    input  logic       ex_is_load,
    input  logic [3:0] ex_wc,
    input  logic [3:0] id_ra,
    input  logic [3:0] id_rb,
    input  logic       id_use_ra,
    input  logic       id_use_rb,
    output logic       hazard
);

    logic ra_hit;
    logic rb_hit;

    assign ra_hit = id_use_ra && (ex_wc == id_ra);
    assign rb_hit = id_use_rb && (ex_wc == id_rb);
    assign hazard = ex_is_load && (ra_hit || rb_hit);

endmodule

// File: rtl/fetch_sequencer.sv
// Boot-load / run / flush / halt sequencer gating the PC and IF/ID register.
// Optional performance counters are built when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int LOAD_CYCLES  = 16,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [1:0]       tf_sel,
    input  logic             halt,
    input  logic             ex_is_load,
    input  logic [3:0]       ex_wc,
    input  logic [3:0]       id_ra,
    input  logic [3:0]       id_rb,
    input  logic             id_use_ra,
    input  logic             id_use_rb,
    output logic             pc_reset,
    output logic             rb_reset,
    output logic             tf_reset,
    output logic             im_read_file,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             id_bubble,
    output logic             busy,
    output logic [2:0]       state
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_cycles,
    output logic [CNT_W-1:0] perf_stalls,
    output logic [CNT_W-1:0] perf_flushes
`endif
);

    localparam logic [SEQ_CNT_W-1:0] LOAD_LAST  = SEQ_CNT_W'(LOAD_CYCLES - 1);
    localparam logic [SEQ_CNT_W-1:0] FLUSH_LAST = SEQ_CNT_W'(FLUSH_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [SEQ_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   hazard;
    logic                   redirect;
    logic                   resets_on;

    load_use_detect u_load_use_detect (
        .ex_is_load (ex_is_load),
        .ex_wc      (ex_wc),
        .id_ra      (id_ra),
        .id_rb      (id_rb),
        .id_use_ra  (id_use_ra),
        .id_use_rb  (id_use_rb),
        .hazard     (hazard)
    );

    assign redirect = (tf_sel != TF_SEQ);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resets_on    = 1'b0;
        im_read_file = 1'b0;
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        ifid_flush   = 1'b0;
        id_bubble    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                resets_on  = 1'b1;
                ifid_flush = 1'b1;
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                resets_on    = 1'b1;
                im_read_file = (cnt_q == '0);
                if (cnt_q == LOAD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // halt outranks redirect, which outranks the load-use stall
                if (halt) begin
                    state_d = ST_HALT;
                end else if (redirect) begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else if (hazard) begin
                    id_bubble = 1'b1;
                end else begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                end
            end
            ST_FLUSH: begin
                pc_we      = 1'b1;
                ifid_we    = 1'b1;
                ifid_flush = 1'b1;
                if (cnt_q == FLUSH_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign pc_reset = resets_on;
    assign rb_reset = resets_on;
    assign tf_reset = resets_on;
    assign busy     = is_busy(state_q);
    assign state    = state_q;

`ifdef FETCH_SEQ_PERF_EN
    logic [CNT_W-1:0] perf_cycles_q, perf_cycles_d;
    logic [CNT_W-1:0] perf_stalls_q, perf_stalls_d;
    logic [CNT_W-1:0] perf_flushes_q, perf_flushes_d;
    logic             in_run;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_run = (state_q == ST_RUN);

    always_comb begin
        perf_cycles_d  = perf_cycles_q;
        perf_stalls_d  = perf_stalls_q;
        perf_flushes_d = perf_flushes_q;
        if (state_q == ST_IDLE && start) begin
            perf_cycles_d  = '0;
            perf_stalls_d  = '0;
            perf_flushes_d = '0;
        end else begin
            if (in_run || state_q == ST_FLUSH) begin
                perf_cycles_d = sat_inc(perf_cycles_q);
            end
            if (in_run && !halt && redirect) begin
                perf_flushes_d = sat_inc(perf_flushes_q);
            end
            if (in_run && !halt && !redirect && hazard) begin
                perf_stalls_d = sat_inc(perf_stalls_q);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            perf_cycles_q  <= '0;
            perf_stalls_q  <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_cycles_q  <= perf_cycles_d;
            perf_stalls_q  <= perf_stalls_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_stalls  = perf_stalls_q;
    assign perf_flushes = perf_flushes_q;
`endif

endmodule
